// File: rtl/rom_stream_loader.sv
// Routes ioctl download bytes to BIOS/cart memories, stripping an optional
// 128-byte "ATARI" cart header after a short elastic-buffer detection window.
module rom_stream_loader #(
  parameter int ADDR_W      = 25,
  parameter int MEM_AW      = 18,
  parameter int NUM_TARGETS = 2,
  parameter int HDR_TARGET  = 1,
  parameter int HDR_LEN     = 128,
  parameter int DET_LEN     = 6,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic                   ioctl_wr,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [7:0]             mem_data,
  output logic [NUM_TARGETS-1:0] mem_we,
  output logic                   hdr_valid,
  output logic [15:0]            hdr_flags,
  output logic [7:0]             hdr_region,
  output logic [31:0]            payload_size,
  output logic                   load_done,
  output logic                   busy,
  output logic                   sys_hold
);

  localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [39:0] MAGIC = {8'h49, 8'h52, 8'h41, 8'h54, 8'h41};

  typedef enum logic [2:0] {
    S_IDLE, S_DETECT, S_PASS, S_STRIP, S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_dl_q;
  logic                  r_pend;
  logic [TW-1:0]         r_tgt;
  logic [ADDR_W-1:0]     r_fa [FIFO_DEPTH];
  logic [7:0]            r_fd [FIFO_DEPTH];
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_fcnt;
  logic                  r_ovf;
  logic                  r_det_seen;
  logic [4:0]            r_hit;
  logic [31:0]           r_size;
  logic [MEM_AW-1:0]     r_mem_addr;
  logic [7:0]            r_mem_data;
  logic [NUM_TARGETS-1:0] r_mem_we;
  logic                  r_hdr_valid;
  logic [15:0]           r_hdr_flags;
  logic [7:0]            r_hdr_region;
  logic [31:0]           r_payload;
  logic                  r_load_done;
  logic                  r_busy;
  logic                  r_sys_hold;

  logic                  w_rise;
  logic                  w_start;
  logic                  w_active;
  logic                  w_push;
  logic                  w_push_ok;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [CW-1:0]         w_fcnt_nxt;
  logic [TW-1:0]         w_tgt_in;
  logic [TW-1:0]         w_cur_tgt;
  logic                  w_hdr_ld;
  logic [ADDR_W-1:0]     w_head_a;
  logic [7:0]            w_head_d;
  logic [MEM_AW-1:0]     w_sub;

  assign w_rise    = ioctl_download & ~r_dl_q;
  assign w_start   = (r_state == S_IDLE) & (w_rise | r_pend);
  assign w_active  = (r_state == S_DETECT) | (r_state == S_PASS) |
                     (r_state == S_STRIP);
  assign w_push    = ioctl_wr & (w_active | w_start);
  assign w_empty   = (r_fcnt == '0);
  assign w_full    = (r_fcnt == CW'(FIFO_DEPTH));
  assign w_pop     = ((r_state == S_PASS) | (r_state == S_STRIP)) & ~w_empty;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_fcnt_nxt = r_fcnt + CW'(w_push_ok) - CW'(w_pop);
  assign w_tgt_in  = (ioctl_index >= 8'(NUM_TARGETS - 1)) ?
                     TW'(NUM_TARGETS - 1) : ioctl_index[TW-1:0];
  assign w_cur_tgt = w_start ? w_tgt_in : r_tgt;
  assign w_hdr_ld  = (w_cur_tgt == TW'(HDR_TARGET));
  assign w_head_a  = r_fa[r_rp];
  assign w_head_d  = r_fd[r_rp];
  assign w_sub     = w_head_a[MEM_AW-1:0] - MEM_AW'(HDR_LEN);

  always_ff @(posedge clk_sys) begin
    if (w_push_ok) begin
      r_fa[r_wp] <= ioctl_addr;
      r_fd[r_wp] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_dl_q       <= 1'b0;
      r_pend       <= 1'b0;
      r_tgt        <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_fcnt       <= '0;
      r_ovf        <= 1'b0;
      r_det_seen   <= 1'b0;
      r_hit        <= '0;
      r_size       <= '0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_we     <= '0;
      r_hdr_valid  <= 1'b0;
      r_hdr_flags  <= '0;
      r_hdr_region <= '0;
      r_payload    <= '0;
      r_load_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_sys_hold   <= 1'b1;
    end else begin
      r_dl_q      <= ioctl_download;
      r_mem_we    <= '0;
      r_load_done <= 1'b0;
      r_busy      <= ioctl_download | (w_fcnt_nxt != '0);
      r_fcnt      <= w_fcnt_nxt;
      if (w_push_ok)
        r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop)
        r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
      if (w_push & w_full & ~w_pop)
        r_ovf <= 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_pend     <= 1'b0;
            r_tgt      <= w_tgt_in;
            r_size     <= '0;
            r_det_seen <= 1'b0;
            r_hit      <= '0;
            if (w_tgt_in == TW'(HDR_TARGET)) begin
              r_hdr_valid  <= 1'b0;
              r_hdr_flags  <= '0;
              r_hdr_region <= '0;
              r_state      <= S_DETECT;
            end else begin
              r_state <= S_PASS;
            end
          end
        end
        S_DETECT: begin
          if (r_det_seen) begin
            r_hdr_valid <= &r_hit;
            r_state     <= (&r_hit) ? S_STRIP : S_PASS;
          end else if (!ioctl_download) begin
            r_state <= S_PASS;
          end
        end
        S_PASS, S_STRIP: begin
          if (w_pop) begin
            if (r_state == S_PASS || w_head_a >= ADDR_W'(HDR_LEN)) begin
              r_mem_we[r_tgt] <= 1'b1;
              r_mem_addr <= (r_state == S_PASS) ?
                            w_head_a[MEM_AW-1:0] : w_sub;
              r_mem_data <= w_head_d;
              r_size     <= r_size + 32'd1;
            end
          end else if (!ioctl_download && !w_push) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_load_done <= 1'b1;
          if (r_tgt == TW'(HDR_TARGET)) begin
            r_payload  <= r_size;
            r_sys_hold <= 1'b0;
          end
          if (w_rise)
            r_pend <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Header fields and magic are tracked as bytes arrive, ahead of the pop
      if (w_push) begin
        if (ioctl_addr == ADDR_W'(DET_LEN - 1))
          r_det_seen <= 1'b1;
        for (int i = 1; i <= 5; i++)
          if (ioctl_addr == ADDR_W'(i) && ioctl_dout == MAGIC[8*(i-1) +: 8])
            r_hit[i-1] <= 1'b1;
        if (w_hdr_ld) begin
          if (ioctl_addr == ADDR_W'(53)) r_hdr_flags[15:8] <= ioctl_dout;
          if (ioctl_addr == ADDR_W'(54)) r_hdr_flags[7:0]  <= ioctl_dout;
          if (ioctl_addr == ADDR_W'(57)) r_hdr_region      <= ioctl_dout;
        end
      end
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_data     = r_mem_data;
  assign mem_we       = r_mem_we;
  assign hdr_valid    = r_hdr_valid;
  assign hdr_flags    = r_hdr_flags;
  assign hdr_region   = r_hdr_region;
  assign payload_size = r_payload;
  assign load_done    = r_load_done;
  assign busy         = r_busy;
  assign sys_hold     = r_sys_hold;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Directed bench for rom_stream_loader with a write scoreboard.
module tb_rom_stream_loader;

  localparam int HDR_LEN = 128;

  typedef struct packed {
    logic [1:0]  we;
    logic [17:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl;
  logic [7:0]  idx;
  logic [24:0] addr;
  logic [7:0]  dout;
  logic        wr;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data;
  logic [1:0]  mem_we;
  logic        hdr_valid;
  logic [15:0] hdr_flags;
  logic [7:0]  hdr_region;
  logic [31:0] payload_size;
  logic        load_done;
  logic        busy;
  logic        sys_hold;

  int  checks = 0;
  int  errors = 0;
  int  n_writes = 0;
  int  n_done = 0;
  int  peak = 0;
  wr_t sb[$];

  always #5 clk = ~clk;

  rom_stream_loader dut (
    .clk_sys(clk), .reset(rst), .ioctl_download(dl),
    .ioctl_index(idx), .ioctl_addr(addr), .ioctl_dout(dout),
    .ioctl_wr(wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .hdr_valid(hdr_valid), .hdr_flags(hdr_flags),
    .hdr_region(hdr_region), .payload_size(payload_size),
    .load_done(load_done), .busy(busy), .sys_hold(sys_hold)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input bit hdr, input int seed,
                                       input int a);
    logic [7:0] v;
    v = 8'((a * 13 + seed) ^ (a >> 8));
    if (hdr) begin
      case (a)
        1:  v = 8'h41;
        2:  v = 8'h54;
        3:  v = 8'h41;
        4:  v = 8'h52;
        5:  v = 8'h49;
        53: v = 8'h00;
        54: v = 8'h12;
        57: v = 8'h01;
        default: ;
      endcase
    end else if (a == 1) begin
      v = 8'h00;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we !== 2'b00) begin
        n_writes++;
        if (sb.size() == 0)
          chk("unexpected_wr", {46'd0, mem_we}, 64'd0);
        else
          chk("wr", {36'd0, mem_we, mem_addr, mem_data}, {36'd0, sb.pop_front()});
      end
      if (load_done) n_done++;
      if (int'(dut.r_fcnt) > peak) peak = int'(dut.r_fcnt);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_load(input logic [7:0] li, input int n, input bit hdr,
                         input int seed, input int rst_at);
    int  base_w;
    int  base_d;
    int  exp_w;
    wr_t e;
    logic [1:0] oh;
    base_w = n_writes;
    base_d = n_done;
    oh = (li == 8'd0) ? 2'b01 : 2'b10;
    exp_w = hdr ? ((n > HDR_LEN) ? n - HDR_LEN : 0) : n;
    @(posedge clk); #1;
    dl = 1'b1;
    idx = li;
    @(posedge clk); #1;
    for (int a = 0; a < n; a++) begin
      if (a == rst_at) begin
        rst = 1'b1;
        wr = 1'b0;
        dl = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mem_we", {62'd0, mem_we}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_sys_hold", {63'd0, sys_hold}, 64'd1);
        chk("rst_fifo_cnt", {60'd0, dut.r_fcnt}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      addr = 25'(a);
      dout = fbyte(hdr, seed, a);
      wr = 1'b1;
      if (!hdr) begin
        e.we = oh; e.addr = 18'(a); e.data = dout;
        sb.push_back(e);
      end else if (a >= HDR_LEN) begin
        e.we = oh; e.addr = 18'(a - HDR_LEN); e.data = dout;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    wr = 1'b0;
    @(posedge clk); #1;
    dl = 1'b0;
    for (int k = 0; k < 200 && n_done == base_d; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("load_done_cnt", 64'(n_done - base_d), 64'd1);
    chk("write_cnt", 64'(n_writes - base_w), 64'(exp_w));
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; dl = 1'b0; idx = '0; addr = '0; dout = '0; wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_mem_we", {62'd0, mem_we}, 64'd0);
    chk("reset_sys_hold", {63'd0, sys_hold}, 64'd1);
    chk("reset_load_done", {63'd0, load_done}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hdr", {39'd0, hdr_valid, hdr_flags, hdr_region}, 64'd0);
    chk("reset_payload", {32'd0, payload_size}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_load(8'd0, 4096, 1'b0, 3, -1);
    chk("bios_sys_hold", {63'd0, sys_hold}, 64'd1);
    chk("bios_payload", {32'd0, payload_size}, 64'd0);
    chk("bios_hdr_valid", {63'd0, hdr_valid}, 64'd0);

    do_load(8'd1, HDR_LEN + 16384, 1'b1, 7, -1);
    chk("hdr_valid", {63'd0, hdr_valid}, 64'd1);
    chk("hdr_flags", {48'd0, hdr_flags}, 64'h0012);
    chk("hdr_region", {56'd0, hdr_region}, 64'h01);
    chk("hdr_payload", {32'd0, payload_size}, 64'd16384);
    chk("hdr_sys_hold", {63'd0, sys_hold}, 64'd0);

    do_load(8'd0, 512, 1'b0, 11, -1);
    chk("bios2_hdr", {39'd0, hdr_valid, hdr_flags, hdr_region}, {39'd0, 1'b1, 16'h0012, 8'h01});
    chk("bios2_payload", {32'd0, payload_size}, 64'd16384);
    chk("bios2_sys_hold", {63'd0, sys_hold}, 64'd0);

    do_load(8'd5, 4096, 1'b0, 19, -1);
    chk("plain_hdr_valid", {63'd0, hdr_valid}, 64'd0);
    chk("plain_payload", {32'd0, payload_size}, 64'd4096);

    do_load(8'd1, 3, 1'b0, 23, -1);
    chk("short_hdr_valid", {63'd0, hdr_valid}, 64'd0);
    chk("short_payload", {32'd0, payload_size}, 64'd3);

    do_load(8'd1, 100, 1'b1, 29, -1);
    chk("hdronly_valid", {63'd0, hdr_valid}, 64'd1);
    chk("hdronly_payload", {32'd0, payload_size}, 64'd0);

    chk("peak_ok", 64'(peak <= 7), 64'd1);
    chk("ovf_flag", {63'd0, dut.r_ovf}, 64'd0);

    do_load(8'd1, HDR_LEN + 1024, 1'b1, 31, 300);
    repeat (3) @(negedge clk);
    chk("post_rst_mem_we", {62'd0, mem_we}, 64'd0);
    chk("post_rst_payload", {32'd0, payload_size}, 64'd0);

    do_load(8'd1, HDR_LEN + 512, 1'b1, 37, -1);
    chk("reload_valid", {63'd0, hdr_valid}, 64'd1);
    chk("reload_flags", {48'd0, hdr_flags}, 64'h0012);
    chk("reload_payload", {32'd0, payload_size}, 64'd512);
    chk("reload_sys_hold", {63'd0, sys_hold}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_stream_loader.md
Name: rom_stream_loader

Overview:
- Sits between hps_io's ioctl download stream and the BIOS/cart dual-port RAMs in the emu top level.
- Routes each download to one of NUM_TARGETS memories, selected by ioctl_index.
- For the cart target, detects an "ATARI" header, strips it and captures its fields; headerless images pass through unchanged.
- A small elastic FIFO withholds early bytes until the header decision is made; the block also produces load-done and system-hold signals.

Parameters:
ADDR_W, 25, ioctl_addr width
MEM_AW, 18, memory write address width
NUM_TARGETS, 2, number of memory write-enable outputs
HDR_TARGET, 1, target index subject to header detection/stripping
HDR_LEN, 128, header length in bytes
DET_LEN, 6, bytes needed to decide header presence (magic at bytes 1..5)
FIFO_DEPTH, 8, elastic buffer depth; must be >= DET_LEN+1

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous active-high reset
ioctl_download  in  1  download active
ioctl_index  in  8  download target index
ioctl_addr  in  ADDR_W  byte address of ioctl_dout
ioctl_dout  in  8  byte data
ioctl_wr  in  1  byte strobe, at most one per clock
mem_addr  out  MEM_AW  memory write address
mem_data  out  8  memory write data
mem_we  out  NUM_TARGETS  one-hot write enable
hdr_valid  out  1  last HDR_TARGET load carried a header
hdr_flags  out  16  header bytes 53 (MSB) and 54
hdr_region  out  8  header byte 57
payload_size  out  32  bytes written to memory by the last HDR_TARGET load
load_done  out  1  one-cycle pulse when a load has fully drained
busy  out  1  download active or FIFO non-empty
sys_hold  out  1  high from reset until the first HDR_TARGET load completes

Behaviour:
- Reset values: all outputs 0, except sys_hold=1. FIFO empty, state IDLE.
- Target select: tgt = min(ioctl_index, NUM_TARGETS-1), latched on the rising edge of ioctl_download.
- States:
  - IDLE: waits for the ioctl_download rising edge. On that edge, clears the hdr_* outputs if tgt==HDR_TARGET, zeroes the size counter, then goes to DETECT if tgt==HDR_TARGET, otherwise to PASS.
  - DETECT: pushes every ioctl_wr byte with its address; output stalled.
    - Magic compare: bytes at addresses 1..5 compared to 0x41,0x54,0x41,0x52,0x49 ("ATARI").
    - Decision is taken the clock after the byte with address DET_LEN-1 is pushed, or on the falling edge of ioctl_download if that comes first (then headerless).
    - Goes to STRIP if the magic matched, otherwise PASS.
  - PASS: FIFO pops one entry per clock while non-empty. mem_addr = addr[MEM_AW-1:0], mem_we[tgt]=1.
  - STRIP: entries with addr < HDR_LEN are popped and dropped. Others are written with mem_addr = (addr-HDR_LEN)[MEM_AW-1:0].
    - Header bytes 53, 54 and 57 are captured into hdr_flags/hdr_region as they are pushed, regardless of state.
    - hdr_valid is set on entry to STRIP.
  - Exit: when ioctl_download=0 and the FIFO is empty in PASS/STRIP, go to DONE.
  - DONE: one cycle; pulses load_done. If tgt==HDR_TARGET, updates payload_size and clears sys_hold. Then goes to IDLE.
- Write latency: mem_we asserts exactly 1 clock after a pop is granted; outputs are registered. mem_we is 0 on cycles with no write.
- payload_size counts mem_we pulses for HDR_TARGET loads. It is loaded in DONE and holds its old value otherwise.
- FIFO: push and pop in the same cycle are allowed. Push while full must not occur given FIFO_DEPTH >= DET_LEN+1; implement a sticky internal overflow flag for assertions.
- A new ioctl_download rising edge seen in DONE is honoured on the following IDLE cycle.
- Non-sequential ioctl_addr is accepted; each byte is handled independently by its own address.
- Reset mid-load: FIFO flushed, no further mem_we, sys_hold returns to 1.
- Header present but file shorter than HDR_LEN: no writes, payload_size=0, load_done still pulses.

Test Plan:
- Headered load: index 1, 128-byte header with "ATARI" at bytes 1..5, flags 0x0012 at 53/54, region 0x01 at 57, then 16 KiB payload back-to-back -> first mem_we[1] has addr 0, data = file byte 128; 16384 writes; payload_size=16384; hdr_valid=1; hdr_flags=0x0012; hdr_region=0x01; one load_done; sys_hold falls.
- Headerless load: index 1, 4 KiB 2600 image, byte1=0x00 -> writes at raw addresses 0..4095 including bytes 0..5, hdr_valid=0, payload_size=4096.
- BIOS load: index 0, 4 KiB -> only mem_we[0] pulses at addresses 0..4095; hdr_* unchanged; payload_size unchanged; sys_hold unaffected.
- Short download: index 1, 3 bytes then ioctl_download falls -> decision headerless, 3 writes at 0..2, load_done after drain.
- Stall/backpressure: ioctl_wr every clock during DETECT -> FIFO peak occupancy <= DET_LEN+1, overflow flag stays 0, no byte lost or duplicated.
- Reset at byte 300 of a headered load -> mem_we=0 next clock, FIFO empty, sys_hold=1; a reload after reset completes correctly.
